// File: rtl/debounce_bank.sv
// N-channel push-button debouncer: 2-flop synchroniser, per-channel
// stability qualification, one-cycle press strobe and optional auto-repeat.
//
// state | meaning
// ------+-----------------------------------------------
// LOW   | debounced level 0, synchronised input low
// RISE  | input high, qualifying before accepting press
// HIGH  | debounced level 1, auto-repeat timer running
// FALL  | input low, qualifying before accepting release
module debounce_bank #(
    parameter int           N            = 2,
    parameter int           STABLE_CNT   = 1_000_000,
    parameter int           REPEAT_DELAY = 50_000_000,
    parameter int           REPEAT_RATE  = 10_000_000,
    parameter logic [N-1:0] REPEAT_EN    = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse
);

    localparam int CW   = $clog2(STABLE_CNT);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
    localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] RPT_ONE   = RW'(1);

    typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;

    logic [N-1:0] sync_a;
    logic [N-1:0] sync_s;
    logic [N-1:0] level_nxt;
    logic [N-1:0] pulse_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_s <= '0;
            level  <= '0;
            pulse  <= '0;
        end else begin
            sync_a <= din;
            sync_s <= sync_a;
            level  <= level_nxt;
            pulse  <= pulse_nxt;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic [RW-1:0] rpt, rpt_nxt;
        logic          lvl_nxt;
        logic          pls_nxt;
        logic          s;

        assign s            = sync_s[i];
        assign level_nxt[i] = lvl_nxt;
        assign pulse_nxt[i] = pls_nxt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= LOW;
                cnt   <= '0;
                rpt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                rpt   <= rpt_nxt;
            end
        end

        // rpt only moves while settled in HIGH, so FALL excursions freeze it
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rpt_nxt   = rpt;
            lvl_nxt   = level[i];
            pls_nxt   = 1'b0;
            case (state)
                LOW: begin
                    if (s) begin
                        state_nxt = RISE;
                        cnt_nxt   = '0;
                    end
                end
                RISE: begin
                    if (!s) begin
                        state_nxt = LOW;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HIGH;
                        lvl_nxt   = 1'b1;
                        pls_nxt   = 1'b1;
                        rpt_nxt   = RPT_DELAY;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_nxt = FALL;
                        cnt_nxt   = '0;
                    end else if (REPEAT_EN[i]) begin
                        if (rpt == RPT_ONE) begin
                            pls_nxt = 1'b1;
                            rpt_nxt = RPT_RATE;
                        end else begin
                            rpt_nxt = rpt - RW'(1);
                        end
                    end
                end
                FALL: begin
                    if (s) begin
                        state_nxt = HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = LOW;
                        lvl_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: run-length/press-count reference model compared
// every cycle, plus directed scenarios with hand-computed edge timings.
module tb_debounce_bank;
    localparam int N  = 2;
    localparam int ST = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam logic [N-1:0] REN = 2'b10;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] din   = '0;
    logic [N-1:0] level;
    logic [N-1:0] pulse;

    int n_checks = 0;
    int n_errors = 0;

    debounce_bank #(
        .N(N), .STABLE_CNT(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_EN(REN)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .level(level), .pulse(pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level flips once the synchronised input has differed
    // from it for ST+1 consecutive edges; repeats count settled-high edges.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_pulse = '0;
    int m_run [N];
    int m_act [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_act[i] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
                for (int i = 0; i < N; i++) begin
                    m_run[i] = 0;
                    m_act[i] = 0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    logic s_cur;
                    s_cur      = m_s2[i];
                    m_pulse[i] = 1'b0;
                    if (s_cur != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == ST + 1) begin
                            m_level[i] = s_cur;
                            m_run[i]   = 0;
                            if (s_cur) begin
                                m_pulse[i] = 1'b1;
                                m_act[i]   = 0;
                            end
                        end
                    end else begin
                        if (m_level[i] && m_run[i] == 0 && REN[i]) begin
                            m_act[i]++;
                            if (m_act[i] == RD || (m_act[i] > RD && (m_act[i] - RD) % RR == 0))
                                m_pulse[i] = 1'b1;
                        end
                        m_run[i] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = din;
            end
        end
    end

    always @(negedge clk) begin
        check("model_level", 32'(level), 32'(m_level));
        check("model_pulse", 32'(pulse), 32'(m_pulse));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p, l;
        logic [6:0] pat;
        logic exp_p;

        #1;
        check("reset_level", 32'(level), 32'h0);
        check("reset_pulse", 32'(pulse), 32'h0);
        step(3);
        reset = 1'b0;
        step(2);

        // clean press on ch0: first sampling edge k, acceptance at k+6
        din[0] = 1'b1;
        step(6);
        check("press_level_early", 32'(level[0]), 32'h0);
        step(1);
        check("press_level", 32'(level[0]), 32'h1);
        check("press_pulse", 32'(pulse[0]), 32'h1);
        p = 0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            if (pulse[0]) p++;
        end
        check("ch0_no_repeat", 32'(p), 32'h0);

        // two-sample low glitch while high
        din[0] = 1'b0;
        step(2);
        din[0] = 1'b1;
        p = 0; l = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (pulse[0]) p++;
            if (!level[0]) l++;
        end
        check("glitch_pulses", 32'(p), 32'h0);
        check("glitch_level_drop", 32'(l), 32'h0);

        // release ch0: level falls at j+6
        din[0] = 1'b0;
        step(6);
        check("release_level_early", 32'(level[0]), 32'h1);
        step(1);
        check("release_level", 32'(level[0]), 32'h0);
        step(3);

        // bounce pattern 1,1,0,1,1,1,0 then hold low
        pat = 7'b1101110;
        p = 0; l = 0;
        for (int b = 6; b >= 0; b--) begin
            din[0] = pat[b];
            step(1);
            if (pulse[0]) p++;
            if (level[0]) l++;
        end
        din[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (pulse[0]) p++;
            if (level[0]) l++;
        end
        check("bounce_pulses", 32'(p), 32'h0);
        check("bounce_level", 32'(l), 32'h0);

        // auto-repeat on ch1: E=k+6, repeats at E+10, E+13, ...; release after edge k+35
        din[1] = 1'b1;
        for (int o = 0; o < 46; o++) begin
            step(1);
            exp_p = (o == 6) || (o >= 16 && o <= 37 && (o - 16) % 3 == 0);
            check("repeat_pulse", 32'(pulse[1]), 32'(exp_p));
            if (o == 5)  check("repeat_level_pre", 32'(level[1]), 32'h0);
            if (o == 6)  check("repeat_level_acc", 32'(level[1]), 32'h1);
            if (o == 41) check("repeat_release_early", 32'(level[1]), 32'h1);
            if (o == 42) check("repeat_release", 32'(level[1]), 32'h0);
            if (o == 35) din[1] = 1'b0;
        end
        step(3);

        // simultaneous press on both channels
        din = 2'b11;
        step(6);
        check("simul_pulse_early", 32'(pulse), 32'h0);
        step(1);
        check("simul_pulse", 32'(pulse), 32'h3);
        check("simul_level", 32'(level), 32'h3);
        step(1);
        check("simul_pulse_end", 32'(pulse), 32'h0);

        // asynchronous reset mid-repeat, inputs still held
        step(11);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_level", 32'(level), 32'h0);
        check("async_reset_pulse", 32'(pulse), 32'h0);
        step(2);
        reset = 1'b0;
        step(6);
        check("post_reset_early", 32'(pulse), 32'h0);
        step(1);
        check("post_reset_pulse", 32'(pulse), 32'h3);
        check("post_reset_level", 32'(level), 32'h3);

        // randomized: bouncy phase, then long holds, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            step(1);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 1499) == 0) reset = 1'b1;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) din[i] = ~din[i];
        end
        for (int c = 0; c < 6000; c++) begin
            step(1);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 1999) == 0) reset = 1'b1;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 24) == 0) din[i] = ~din[i];
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised, multi-channel successor to the single-input `debounce` used on the step-clock and memory-write buttons. It synchronises N raw push-button or switch inputs to `clk` and filters each one independently. Each channel provides a debounced level, a one-cycle press pulse and an optional auto-repeat pulse train. It sits between the board buttons and the CPU execution unit and memory in the top level, so a single instance replaces per-button `debounce` instances.

## Interface
- `N`, 2: number of independent channels.
- `STABLE_CNT`, 1_000_000: cycles an input must be stable before its level changes. Legal range ≥2; the default is 10 ms at 100 MHz.
- `REPEAT_DELAY`, 50_000_000: cycles from press acceptance to the first repeat pulse. Legal range ≥1.
- `REPEAT_RATE`, 10_000_000: cycles between subsequent repeat pulses. Legal range ≥1.
- `REPEAT_EN`, {N{1'b0}}: per-channel bitmask. A 1 enables auto-repeat on that channel.
- `clk`  input  1  system clock; all state is updated on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `din`  input  N  raw, asynchronous button inputs, active-high.
- `level`  output  N  debounced level per channel.
- `pulse`  output  N  one-cycle strobe per channel on accepted press and on each repeat.

## Operation
- **Synchroniser:** each `din[i]` passes through a 2-flop synchroniser. `s[i]` denotes the second flop. The FSM sees only `s[i]`.
- **Per-channel state:** each channel has its own FSM with states LOW, RISE, HIGH and FALL.
- **Stability counter:** one counter per channel, `$clog2(STABLE_CNT)` bits.
- **Repeat counter:** one counter per channel, `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)` bits.
- **LOW:**
  - `s=1` moves to RISE and sets cnt←0.
  - `s=0` stays in LOW.
- **RISE:**
  - `s=0` returns to LOW. This is a bounce; no output change.
  - `s=1` with cnt<STABLE_CNT-1 sets cnt←cnt+1.
  - `s=1` with cnt==STABLE_CNT-1 moves to HIGH. On the same edge: `level`←1, `pulse`←1, rpt←REPEAT_DELAY.
- **HIGH:**
  - `s=0` moves to FALL and sets cnt←0. rpt is frozen.
  - `s=1` with REPEAT_EN[i]=1: if rpt==1, `pulse`←1 and rpt←REPEAT_RATE; otherwise rpt←rpt-1.
  - `s=1` with REPEAT_EN[i]=0: rpt is unused and no repeat pulses are issued.
- **FALL:**
  - `s=1` returns to HIGH with `level` still 1. rpt resumes from its frozen value and no new press pulse is issued.
  - `s=0` with cnt==STABLE_CNT-1 moves to LOW and sets `level`←0. No pulse is issued on release.
  - Otherwise cnt←cnt+1.
- **Pulse width:** `pulse[i]` is registered and defaults to 0 every cycle. It is high for exactly one cycle per event.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- **Reset:** `reset` asserted at any time, including mid-count or mid-repeat, asynchronously drives:
  - all FSMs to LOW;
  - both synchroniser flops, cnt and rpt to 0;
  - `level` and `pulse` to 0.

  After release, an input already held high is treated as a new press and follows the full RISE path.

## Timing
- **Reset values:** `level`=0 and `pulse`=0 for all channels.
- **Press latency:** let edge k be the first edge that samples `din[i]`=1, with the input held high thereafter.
  - RISE is entered at k+2.
  - `level` and `pulse` assert at edge k+2+STABLE_CNT.
- **Release latency:** symmetric. `level` deasserts at edge j+2+STABLE_CNT, where j is the first edge sampling 0.
- **Bounce rejection:** any opposite sample during RISE or FALL restarts qualification from the beginning.
- **Minimum input width:** a glitch shorter than STABLE_CNT cycles, as seen at `s`, never changes `level`.
- **Auto-repeat schedule:** with press acceptance at edge E, repeat pulses fire at E+REPEAT_DELAY, then E+REPEAT_DELAY+n·REPEAT_RATE for n≥1. This holds while the channel stays in HIGH with no FALL excursions.
- **Repeat during FALL:** each cycle spent in FALL that returns to HIGH delays all later repeats by that many cycles.
- **Last repeat before release:** a repeat that would fall due in the cycle HIGH→FALL is taken is not issued.

## Test plan
All scenarios use N=2, STABLE_CNT=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_EN=2'b10.
- **Clean press, ch0:** drive `din[0]`=1 sampled first at edge 10 and hold. Required: `level[0]`=1 and a single `pulse[0]` at edge 16. No further pulses on ch0 for 50 cycles.
- **Bounce rejection:** toggle `din[0]` 1,1,0,1,1,1,0 over 7 edges, then hold 0. Required: `level[0]` stays 0 and `pulse[0]` never asserts.
- **Auto-repeat, ch1:** press `din[1]` with acceptance at edge E and hold for 30 cycles. Required: `pulse[1]` at E, E+10, E+13, E+16, … and nothing between. After release, `level[1]` falls 6 edges after the first 0 sample.
- **Release glitch:** with ch0 in HIGH, drive a 2-cycle low glitch. Required: `level[0]` stays 1 and no extra pulse is issued.
- **Simultaneous press:** press both channels on the same edge. Required: `pulse`=2'b11 for one cycle and `level`=2'b11 on the same edge.
- **Reset mid-operation:** assert `reset` asynchronously while ch1 is mid-repeat, between clock edges. Required: `level` and `pulse` read 0 immediately. After release with `din[1]` still held, a fresh press `pulse[1]` occurs 6 edges after the first sampling edge.
